// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: shares one req/gnt/rvalid memory port between the
// instruction-fetch and load/store requesters. Grant order is recorded in a
// small FIFO of source ids so that in-order responses can be steered back.
// Optional build macro: IBEX_MEM_ARB_RR_EN selects two-way round-robin
// arbitration; when undefined, data has fixed priority over instr.
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_req_i,
    input  logic [AddrWidth-1:0] instr_addr_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    output logic [31:0]          instr_rdata_o,
    output logic                 instr_err_o,
    input  logic                 data_req_i,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [AddrWidth-1:0] data_addr_i,
    input  logic [31:0]          data_wdata_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic [31:0]          data_rdata_o,
    output logic                 data_err_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_err_i,
    output logic                 busy_o,
    output logic                 proto_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    // Source ids stored in the FIFO and used as the select value
    localparam logic SRC_INSTR = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                  state_r;
    state_e                  state_next_s;
    logic                    sel_r;
    logic                    sel_s;
    logic                    sel_req_s;
    logic                    mem_req_s;
    logic                    rdy_r;
    logic                    full_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    head_id_s;
    logic                    proto_err_r;
    logic [MaxOutstanding-1:0] fifo_r;
    logic [PtrW-1:0]         wr_ptr_r;
    logic [PtrW-1:0]         rd_ptr_r;
    logic [CntW-1:0]         count_r;
`ifdef IBEX_MEM_ARB_RR_EN
    logic                    rr_r;      // 1: data is favoured on the next contended cycle
`endif

    // Pointer increment wrapping modulo MaxOutstanding
    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        logic [PtrW-1:0] n;
        if (p == PtrW'(MaxOutstanding - 1)) begin
            n = {PtrW{1'b0}};
        end else begin
            n = p + PtrW'(1);
        end
        return n;
    endfunction

    // A full FIFO is judged on the registered count, so a same-cycle pop does not free a slot
    assign full_s    = (count_r >= CntW'(MaxOutstanding));
    assign push_s    = mem_req_s & mem_gnt_i;
    assign pop_s     = mem_rvalid_i & (count_r != {CntW{1'b0}});
    assign head_id_s = fifo_r[rd_ptr_r];

    // Source selection, request gating and lock FSM next state
    always_comb begin
        state_next_s = state_r;
        sel_s        = sel_r;
        sel_req_s    = 1'b0;
        mem_req_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
`ifdef IBEX_MEM_ARB_RR_EN
                if (data_req_i && instr_req_i) begin
                    sel_s = rr_r;
                end else if (data_req_i) begin
                    sel_s = SRC_DATA;
                end else begin
                    sel_s = SRC_INSTR;
                end
`else
                if (data_req_i) begin
                    sel_s = SRC_DATA;
                end else begin
                    sel_s = SRC_INSTR;
                end
`endif
                sel_req_s = (sel_s == SRC_DATA) ? data_req_i : instr_req_i;
                mem_req_s = rdy_r & ~full_s & sel_req_s;
                if (mem_req_s && !mem_gnt_i) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // The offered request must stay put until it is granted
                sel_s     = sel_r;
                sel_req_s = 1'b1;
                mem_req_s = rdy_r & ~full_s & sel_req_s;
                if (mem_gnt_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                sel_s        = sel_r;
                sel_req_s    = 1'b0;
                mem_req_s    = 1'b0;
            end
        endcase
    end

    // Lock state, held selection, ready flag and sticky protocol error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            sel_r       <= SRC_INSTR;
            rdy_r       <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            sel_r   <= sel_s;
            rdy_r   <= 1'b1;
            if (mem_rvalid_i && (count_r == {CntW{1'b0}})) begin
                proto_err_r <= 1'b1;
            end else begin
                proto_err_r <= proto_err_r;
            end
        end
    end

`ifdef IBEX_MEM_ARB_RR_EN
    // Round-robin pointer: after every grant favour the source that was not granted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_r <= SRC_DATA;
        end else if (push_s) begin
            rr_r <= ~sel_s;
        end else begin
            rr_r <= rr_r;
        end
    end
`endif

    // Outstanding-transaction FIFO of source ids and its occupancy count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_r   <= {MaxOutstanding{1'b0}};
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= sel_s;
                wr_ptr_r         <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Downstream payload follows the selected source; fetches are always full-word reads
    assign mem_req_o   = mem_req_s;
    assign mem_we_o    = (sel_s == SRC_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (sel_s == SRC_DATA) ? data_be_i    : 4'hF;
    assign mem_addr_o  = (sel_s == SRC_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = (sel_s == SRC_DATA) ? data_wdata_i : 32'h0000_0000;

    assign instr_gnt_o = mem_gnt_i & mem_req_s & (sel_s == SRC_INSTR);
    assign data_gnt_o  = mem_gnt_i & mem_req_s & (sel_s == SRC_DATA);

    // Responses are steered by the id at the FIFO head; data/err are unqualified
    assign instr_rvalid_o = rdy_r & pop_s & (head_id_s == SRC_INSTR);
    assign data_rvalid_o  = rdy_r & pop_s & (head_id_s == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign busy_o      = rdy_r & (count_r != {CntW{1'b0}});
    assign proto_err_o = proto_err_r;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench for ibex_mem_arbiter: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_ibex_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o, proto_err_o;

    ibex_mem_arbiter #(.MaxOutstanding(MAXO), .AddrWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of source ids in grant order (0 = instr, 1 = data)
    bit q[$];
    bit m_rdy, m_locked, m_lock_src, m_proto;
`ifdef IBEX_MEM_ARB_RR_EN
    bit m_fav_data;
`endif
    // Expectations of the current cycle
    bit e_req, e_src, e_pop, e_ig, e_dg;
    // Observed outputs of the current cycle, for scenario-level checks
    logic        o_req, o_ig, o_dg, o_irv, o_drv, o_busy, o_proto;
    logic [31:0] o_addr, o_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy      = 1'b0;
        m_locked   = 1'b0;
        m_lock_src = 1'b0;
        m_proto    = 1'b0;
`ifdef IBEX_MEM_ARB_RR_EN
        m_fav_data = 1'b1;
`endif
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model at the rising edge
    task automatic step();
        bit full, cand_req;
        @(negedge clk_i);
        full = (q.size() >= MAXO);
        if (m_locked) begin
            e_src    = m_lock_src;
            cand_req = 1'b1;
        end else begin
`ifdef IBEX_MEM_ARB_RR_EN
            if (data_req_i && instr_req_i) e_src = m_fav_data;
            else                           e_src = data_req_i;
`else
            e_src = data_req_i;
`endif
            cand_req = e_src ? data_req_i : instr_req_i;
        end
        e_req = rst_ni && m_rdy && !full && cand_req;
        e_ig  = e_req && mem_gnt_i && !e_src;
        e_dg  = e_req && mem_gnt_i && e_src;
        e_pop = mem_rvalid_i && (q.size() != 0);
        o_req = mem_req_o; o_ig = instr_gnt_o; o_dg = data_gnt_o;
        o_irv = instr_rvalid_o; o_drv = data_rvalid_o; o_busy = busy_o;
        o_proto = proto_err_o; o_addr = mem_addr_o; o_rdata = instr_rdata_o;
        chk("mem_req", mem_req_o, 32'(e_req));
        chk("instr_gnt", instr_gnt_o, 32'(e_ig));
        chk("data_gnt", data_gnt_o, 32'(e_dg));
        chk("instr_rvalid", instr_rvalid_o, 32'(e_pop && q[0] == 1'b0));
        chk("data_rvalid", data_rvalid_o, 32'(e_pop && q[0] == 1'b1));
        chk("busy", busy_o, 32'(q.size() != 0));
        chk("proto_err", proto_err_o, 32'(m_proto));
        if (e_req) begin
            chk("mem_addr", mem_addr_o, e_src ? data_addr_i : instr_addr_i);
            chk("mem_we", mem_we_o, e_src ? 32'(data_we_i) : 32'h0);
            chk("mem_be", mem_be_o, e_src ? 32'(data_be_i) : 32'hF);
            chk("mem_wdata", mem_wdata_o, e_src ? data_wdata_i : 32'h0);
        end
        if (e_pop) begin
            chk("rdata", q[0] ? data_rdata_o : instr_rdata_o, mem_rdata_i);
            chk("err", q[0] ? data_err_o : instr_err_o, 32'(mem_err_i));
        end
        @(posedge clk_i);
        if (!rst_ni) begin
            model_reset();
        end else begin
            if (mem_rvalid_i && q.size() == 0) m_proto = 1'b1;
            if (e_pop) void'(q.pop_front());
            if (e_req && mem_gnt_i) begin
                q.push_back(e_src);
`ifdef IBEX_MEM_ARB_RR_EN
                m_fav_data = !e_src;
`endif
            end
            m_locked   = e_req && !mem_gnt_i;
            m_lock_src = e_src;
            m_rdy      = 1'b1;
        end
        #1;
    endtask

    // Bring all requesters and the memory to a quiet state with the model drained
    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = (q.size() != 0);
            step();
            if (e_ig) instr_req_i = 1'b0;
            if (e_dg) data_req_i = 1'b0;
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    bit arb_exp[4];

    initial begin
        rst_ni = 1'b0;
        instr_req_i = 1'b0; instr_addr_i = 32'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
        model_reset();
        #3;
        chk("reset_mem_req", mem_req_o, 32'h0);
        chk("reset_busy", busy_o, 32'h0);
        chk("reset_proto", proto_err_o, 32'h0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // First cycle after release: not ready yet, request must be held off
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        step();
        chk("rdy_gate_req", o_req, 32'h0);

        // Single fetch (granted now that the arbiter is ready)
        step();
        chk("fetch_gnt", o_ig, 32'h1);
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        step();
        chk("fetch_rvalid", o_irv, 32'h1);
        chk("fetch_rdata", o_rdata, 32'hDEAD_BEEF);
        chk("fetch_busy", o_busy, 32'h1);
        mem_rvalid_i = 1'b0;
        step();
        chk("fetch_idle_busy", o_busy, 32'h0);

        // Lock: data held ungranted for 3 cycles while instr arrives
        data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1;
        data_be_i = 4'h3; data_wdata_i = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin instr_req_i = 1'b1; instr_addr_i = 32'h300; end
            mem_gnt_i = (c == 3);
            step();
            chk("lock_addr", o_addr, 32'h200);
            chk("lock_dgnt", o_dg, (c == 3) ? 32'h1 : 32'h0);
        end
        data_req_i = 1'b0;
        step();
        chk("lock_then_instr", o_ig, 32'h1);
        instr_req_i = 1'b0;
        drain();

        // Backpressure: two outstanding fill the FIFO
        instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
        step(); step();
        step();
        chk("bp_full_blocks", o_req, 32'h0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
        step();
        chk("bp_pop_no_grant", o_req, 32'h0);
        chk("bp_pop_rvalid", o_irv, 32'h1);
        mem_rvalid_i = 1'b0;
        step();
        chk("bp_after_pop", o_ig, 32'h1);
        instr_req_i = 1'b0;
        drain();

        // Ordering: I, D, I granted; responses 1, 2, 3 with same-cycle push+pop
        instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        step();
        instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h500;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1;
        step();
        chk("ord_r1_instr", o_irv, 32'h1);
        chk("ord_r1_data", o_rdata, 32'h1);
        data_req_i = 1'b0; instr_req_i = 1'b1; mem_rdata_i = 32'h2;
        step();
        chk("ord_r2_data", o_drv, 32'h1);
        chk("ord_pushpop_busy", o_busy, 32'h1);
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'h3;
        step();
        chk("ord_r3_instr", o_irv, 32'h1);
        chk("ord_r3_data", o_rdata, 32'h3);
        mem_rvalid_i = 1'b0;
        step();
        chk("ord_idle", o_busy, 32'h0);

        // Arbitration with both requesting every cycle
`ifdef IBEX_MEM_ARB_RR_EN
        arb_exp[0] = 1'b1; arb_exp[1] = 1'b0; arb_exp[2] = 1'b1; arb_exp[3] = 1'b0;
`else
        arb_exp[0] = 1'b1; arb_exp[1] = 1'b1; arb_exp[2] = 1'b1; arb_exp[3] = 1'b1;
`endif
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = (k != 0);
            step();
            chk("arb_data", o_dg, 32'(arb_exp[k]));
            chk("arb_instr", o_ig, 32'(!arb_exp[k]));
        end
        drain();

        // Randomized traffic obeying the hold-until-granted rule
        for (int n = 0; n < 400; n++) begin
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (q.size() != 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
            mem_err_i    = ($urandom_range(0, 7) == 0);
            step();
            if (e_ig || !instr_req_i) begin
                instr_req_i  = ($urandom_range(0, 1) == 1);
                instr_addr_i = $urandom;
            end
            if (e_dg || !data_req_i) begin
                data_req_i   = ($urandom_range(0, 2) == 0);
                data_addr_i  = $urandom;
                data_we_i    = ($urandom_range(0, 1) == 1);
                data_be_i    = 4'($urandom);
                data_wdata_i = $urandom;
            end
        end
        mem_err_i = 1'b0;
        drain();

        // Unexpected response with nothing outstanding
        mem_rvalid_i = 1'b1;
        step();
        chk("proto_no_irv", o_irv, 32'h0);
        chk("proto_no_drv", o_drv, 32'h0);
        mem_rvalid_i = 1'b0;
        step();
        chk("proto_set", o_proto, 32'h1);
        step();
        chk("proto_sticky", o_proto, 32'h1);

        // Reset with two outstanding transactions
        instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        step(); step();
        mem_rvalid_i = 1'b1;
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", busy_o, 32'h0);
        chk("rst_mem_req", mem_req_o, 32'h0);
        chk("rst_igt", instr_gnt_o, 32'h0);
        chk("rst_irv", instr_rvalid_o, 32'h0);
        chk("rst_proto", proto_err_o, 32'h0);
        step();
        rst_ni = 1'b1;
        step();
        chk("rst_release_req", o_req, 32'h0);
        chk("rst_release_irv", o_irv, 32'h0);
        mem_rvalid_i = 1'b0;
        step();
        chk("rst_late_resp_proto", o_proto, 32'h1);
        chk("rst_req_resumes", o_req, 32'h1);
        instr_req_i = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
